// File: rtl/pciecfg_arb.sv
// pciecfg_arb: two-requester round-robin arbiter onto the PCIe config management port.
//
// One command is in flight at a time. The FSM goes IDLE -> BUSY -> RESP -> IDLE.
// Optional feature macro: PCIECFG_ARB_TIMEOUT_EN. When it is defined, a BUSY phase
// that lasts TIMEOUT_CYCLES without cfg_mgmt_rd_wr_done is aborted. The abort
// responds with err=1 and data=32'hFFFF_FFFF.
//
// Ports:
//   clk, rst                    pcie_clk domain; synchronous active-high reset
//   reqN_valid/ready            command handshake; ready pulses for one cycle on grant
//   reqN_wr/dwaddr/byte_en/data command fields (1=write)
//   respN_valid/data/err        one-cycle completion; data and err are 0 when not valid
//   cfg_mgmt_dwaddr/rd_en/wr_en/byte_en/di  command outputs to the core
//   cfg_mgmt_do/rd_wr_done      read data and completion from the core
module pciecfg_arb #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_wr,
    input  logic [9:0]  req0_dwaddr,
    input  logic [3:0]  req0_byte_en,
    input  logic [31:0] req0_data,
    output logic        resp0_valid,
    output logic [31:0] resp0_data,
    output logic        resp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_wr,
    input  logic [9:0]  req1_dwaddr,
    input  logic [3:0]  req1_byte_en,
    input  logic [31:0] req1_data,
    output logic        resp1_valid,
    output logic [31:0] resp1_data,
    output logic        resp1_err,
    output logic [9:0]  cfg_mgmt_dwaddr,
    output logic        cfg_mgmt_rd_en,
    output logic        cfg_mgmt_wr_en,
    output logic [3:0]  cfg_mgmt_byte_en,
    output logic [31:0] cfg_mgmt_di,
    input  logic [31:0] cfg_mgmt_do,
    input  logic        cfg_mgmt_rd_wr_done
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
        $error("pciecfg_arb: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state, state_nx;
    logic        accept, gnt_nx, gnt, last, busy, tmo;
    logic        lat_wr, err;
    logic [9:0]  lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_data, rdata;

`ifdef PCIECFG_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt;
    // Fires on the last permitted BUSY cycle, so the strobe is high for exactly TIMEOUT_CYCLES.
    assign tmo = busy && !cfg_mgmt_rd_wr_done && cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || !busy) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        // With both valid the requester that lost last time wins; last resets to 1 so req0 wins first.
        gnt_nx   = (req0_valid && req1_valid) ? ~last : req1_valid;
        case (state)
            IDLE: if (req0_valid || req1_valid) begin
                accept   = 1'b1;
                state_nx = BUSY;
            end
            BUSY: if (cfg_mgmt_rd_wr_done || tmo) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= 1'b0;
            last     <= 1'b1;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_be   <= '0;
            lat_data <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                gnt      <= gnt_nx;
                last     <= gnt_nx;
                lat_wr   <= gnt_nx ? req1_wr : req0_wr;
                lat_addr <= gnt_nx ? req1_dwaddr : req0_dwaddr;
                lat_be   <= gnt_nx ? req1_byte_en : req0_byte_en;
                lat_data <= gnt_nx ? req1_data : req0_data;
            end
            if (busy && (cfg_mgmt_rd_wr_done || tmo)) begin
                rdata <= tmo ? 32'hFFFF_FFFF : (lat_wr ? 32'h0 : cfg_mgmt_do);
                err   <= tmo;
            end
        end
    end

    always_comb begin
        busy             = state == BUSY;
        req0_ready       = accept && !gnt_nx;
        req1_ready       = accept && gnt_nx;
        cfg_mgmt_rd_en   = busy && !lat_wr;
        cfg_mgmt_wr_en   = busy && lat_wr;
        cfg_mgmt_dwaddr  = busy ? lat_addr : 10'h0;
        cfg_mgmt_byte_en = busy ? lat_be : 4'h0;
        cfg_mgmt_di      = busy ? lat_data : 32'h0;
        resp0_valid      = state == RESP && !gnt;
        resp1_valid      = state == RESP && gnt;
        resp0_data       = resp0_valid ? rdata : 32'h0;
        resp1_data       = resp1_valid ? rdata : 32'h0;
        resp0_err        = resp0_valid && err;
        resp1_err        = resp1_valid && err;
    end
endmodule
